// File: rtl/if_fetch_queue_if.sv
// Fetch-queue handshake bundle: imem request/response channels and the ID-side head channel.
// master = fetch queue, slave = memory/ID environment.
interface if_fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: credit-limited in-order imem fetch, DEPTH-entry {instr, pc+4} queue,
// redirect flush with stale-response dropping. Optional same-cycle response bypass: IFQ_BYPASS_EN.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    if_fetch_queue_if.master           bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUT+1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc4   [DEPTH];

    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_rsp_live;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_rsp_pc4;
    logic [OW-1:0] w_out_next;
    logic [OW-1:0] w_drop_next;

    // Credit check: queued plus in-flight words never exceed the queue size, so a response always fits.
    assign w_req_valid = (r_state == S_RUN) && start && !redirect_valid &&
                         (r_outstanding < OW'(MAX_OUT)) &&
                         ((32'(r_count) + 32'(r_outstanding)) < 32'(DEPTH));
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp_live  = bus.imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_rsp_pc4   = r_resp_pc + 32'd4;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_rsp_live && (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_rsp_live && !(w_bypass && bus.id_ready);
    assign w_pop  = (r_count != '0) && bus.id_ready && !redirect_valid;

    assign w_out_next = r_outstanding + OW'(w_req_fire) - OW'(bus.imem_rsp_valid);

    always_comb begin
        w_drop_next = r_drop_cnt;
        if (redirect_valid)
            w_drop_next = r_outstanding - OW'(bus.imem_rsp_valid);
        else if (bus.imem_rsp_valid && (r_drop_cnt != '0))
            w_drop_next = r_drop_cnt - OW'(1);
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.id_valid       = (r_count != '0) || w_bypass;
    assign bus.id_instr       = (r_count != '0) ? r_mem_instr[r_rd_ptr] :
                                (w_bypass ? bus.imem_rsp_data : 32'd0);
    assign bus.id_pc4         = (r_count != '0) ? r_mem_pc4[r_rd_ptr] :
                                (w_bypass ? w_rsp_pc4 : 32'd0);
    assign occupancy          = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                // resp_pc follows every live response, including bypassed ones
                if (w_rsp_live)
                    r_resp_pc <= w_rsp_pc4;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            case (r_state)
                S_IDLE:  if (start) r_state <= S_RUN;
                S_RUN:   if (redirect_valid && (w_drop_next != '0)) r_state <= S_FLUSH;
                S_FLUSH: if (w_drop_next == '0) r_state <= S_RUN;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= bus.imem_rsp_data;
            r_mem_pc4[r_wr_ptr]   <= w_rsp_pc4;
        end
    end
endmodule
